fetch_control: RTL and testbench
================================

FETCH_CONTROL -- requirements
Module: fetch_control

Interface
REQ-001 Parameter data_size, default 8, width of the program counter and instruction addresses.
REQ-002 Parameter instr_size, default 16, width of the instruction word; opcode is bits [instr_size-1:instr_size-4].
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (rst==0 resets).
REQ-005 enable  input  1  run request; fetching starts or continues only while 1.
REQ-006 count  input  data_size  current PC value from the program counter.
REQ-007 Load_PC  output  1  one-cycle load strobe to the program counter.
REQ-008 Inc_PC  output  1  one-cycle increment strobe to the program counter.
REQ-009 pc_data  output  data_size  load value for the program counter; equals br_target whenever Load_PC==1.
REQ-010 mem_rd  output  1  instruction memory read request, held until mem_ack.
REQ-011 mem_addr  output  data_size  read address; equals count combinationally.
REQ-012 mem_ack  input  1  memory acknowledges; mem_data valid in the same cycle.
REQ-013 mem_data  input  instr_size  instruction word from memory.
REQ-014 br_taken  input  1  redirect request from execute, one-cycle pulse.
REQ-015 br_target  input  data_size  redirect address, valid with br_taken.
REQ-016 ir_out  output  instr_size  registered instruction to the decoder.
REQ-017 ir_valid  output  1  ir_out holds an instruction not yet consumed.
REQ-018 ir_ready  input  1  decoder accepts; transfer when ir_valid&&ir_ready.
REQ-019 halted  output  1  high in the HALTED state.

Function
REQ-020 States: IDLE, REQ, HOLD, HALTED; encoding free.
REQ-021 IDLE: mem_rd=0, ir_valid=0; enable==1 -> REQ next cycle.
REQ-022 REQ: mem_rd=1; on mem_ack, ir_out<=mem_data, Inc_PC=1 in that same cycle, -> HOLD; without mem_ack, stay in REQ.
REQ-023 HOLD: ir_valid=1, ir_out stable, mem_rd=0; on ir_ready: halt opcode (4'hF) -> HALTED, else enable==1 -> REQ, else -> IDLE.
REQ-024 HALTED: mem_rd=0, ir_valid=0, halted=1; exits only on reset or br_taken.
REQ-025 Fetch throughput: at most one instruction per two cycles (REQ, HOLD minimum); mem_ack latency is unbounded.
REQ-026 br_taken in any state: Load_PC=1, pc_data=br_target in that cycle; ir_valid cleared next cycle; -> REQ next cycle when enable==1, else IDLE.
REQ-027 br_taken coincident with mem_ack: branch wins; mem_data discarded, Inc_PC=0, ir_out unchanged.
REQ-028 br_taken coincident with ir_valid&&ir_ready: the transfer completes; the branch still flushes and redirects; halt opcode is ignored.
REQ-029 Load_PC and Inc_PC are never both 1 in the same cycle.
REQ-030 enable dropping in REQ does not abort the outstanding read; the state returns to IDLE after the HOLD hand-off.
REQ-031 PC arithmetic is the counter's; count wrap from all-ones to 0 is a normal fetch, with no special handling.

Reset
REQ-032 rst==0 immediately forces IDLE; ir_out=0, ir_valid=0, mem_rd=0, Load_PC=0, Inc_PC=0, halted=0, pc_data=0.
REQ-033 Reset asserted with a read outstanding abandons the read; a mem_ack arriving after reset release in IDLE is ignored.

Verification
REQ-034 Reset, enable=1, count=0x00, mem_ack after 3 cycles with mem_data=0x1234 -> mem_rd high 3 cycles, Inc_PC single pulse, ir_out=0x1234, ir_valid=1 next cycle.
REQ-035 ir_ready held 0 for 5 cycles in HOLD -> ir_out and ir_valid stable, mem_rd=0, no Inc_PC.
REQ-036 br_taken with br_target=0x40 in the same cycle as mem_ack -> Load_PC=1, pc_data=0x40, Inc_PC=0, ir_valid stays 0, next mem_rd with mem_addr=0x40.
REQ-037 Fetch mem_data=0xF000, accepted -> halted=1 and no further mem_rd; br_taken with br_target=0x10 -> Load_PC=1 and fetch resumes at 0x10.
REQ-038 rst pulsed low while in REQ -> all outputs 0 asynchronously; a later mem_ack with enable=0 -> no IR load and no Inc_PC.
REQ-039 count=0xFF fetched -> Inc_PC pulse; next mem_addr=0x00 and fetch continues normally.

Source files
------------

// File: rtl/fetch_control_if.sv
// Fetch-side bus bundle: instruction memory read port plus the IR hand-off to the decoder.
// The master modport is the fetch controller's view.
interface fetch_control_if #(
    parameter int data_size  = 8,
    parameter int instr_size = 16
);
    logic                  mem_rd;
    logic [data_size-1:0]  mem_addr;
    logic                  mem_ack;
    logic [instr_size-1:0] mem_data;
    logic [instr_size-1:0] ir_out;
    logic                  ir_valid;
    logic                  ir_ready;

    modport master (
        output mem_rd, mem_addr, ir_out, ir_valid,
        input  mem_ack, mem_data, ir_ready
    );

    modport slave (
        input  mem_rd, mem_addr, ir_out, ir_valid,
        output mem_ack, mem_data, ir_ready
    );
endinterface

// File: rtl/fetch_control.sv
// Instruction fetch sequencer: reads memory at the PC, hands the word to the decoder,
// and steps or redirects the program counter.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | not fetching, waiting for enable
//   S_REQ    | memory read outstanding at mem_addr == count
//   S_HOLD   | ir_out valid, waiting for the decoder to accept it
//   S_HALTED | halt opcode consumed; only a branch or reset restarts
module fetch_control #(
    parameter int data_size  = 8,
    parameter int instr_size = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [data_size-1:0] count,
    output logic                 Load_PC,
    output logic                 Inc_PC,
    output logic [data_size-1:0] pc_data,
    input  logic                 br_taken,
    input  logic [data_size-1:0] br_target,
    output logic                 halted,
    fetch_control_if.master      bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_HOLD   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [instr_size-1:0] r_ir;
    logic                  w_fetch_done;
    logic                  w_halt_op;

    assign w_halt_op = (r_ir[instr_size-1 -: 4] == 4'hF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (w_fetch_done) begin
                r_ir <= bus.mem_data;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_fetch_done = 1'b0;
        Inc_PC       = 1'b0;
        bus.mem_rd   = 1'b0;
        bus.ir_valid = 1'b0;
        halted       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                bus.mem_rd = 1'b1;
                // A coincident branch squashes the returning word and the PC step.
                if (bus.mem_ack && !br_taken) begin
                    w_fetch_done = 1'b1;
                    Inc_PC       = 1'b1;
                    w_next       = S_HOLD;
                end
            end
            S_HOLD: begin
                bus.ir_valid = 1'b1;
                if (bus.ir_ready) begin
                    if (w_halt_op) begin
                        w_next = S_HALTED;
                    end else if (enable) begin
                        w_next = S_REQ;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            S_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        // Redirect overrides every other transition, including a pending halt.
        if (br_taken) begin
            w_next = enable ? S_REQ : S_IDLE;
        end
    end

    assign Load_PC      = br_taken && rst;
    assign pc_data      = Load_PC ? br_target : '0;
    assign bus.mem_addr = count;
    assign bus.ir_out   = r_ir;

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control with a small program-counter model driving count.
module tb_fetch_control;

    localparam int DS = 8;
    localparam int IS = 16;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          enable    = 1'b0;
    logic          br_taken  = 1'b0;
    logic [DS-1:0] br_target = '0;
    logic [DS-1:0] count     = '0;
    logic          Load_PC;
    logic          Inc_PC;
    logic          halted;
    logic [DS-1:0] pc_data;

    int n_checks = 0;
    int n_errors = 0;

    fetch_control_if #(.data_size(DS), .instr_size(IS)) bus ();

    fetch_control #(.data_size(DS), .instr_size(IS)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .count     (count),
        .Load_PC   (Load_PC),
        .Inc_PC    (Inc_PC),
        .pc_data   (pc_data),
        .br_taken  (br_taken),
        .br_target (br_target),
        .halted    (halted),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst)         count <= '0;
        else if (Load_PC) count <= pc_data;
        else if (Inc_PC)  count <= count + 8'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        check("ld_inc_excl", {31'b0, Load_PC & Inc_PC}, 32'd0);
    end

    initial begin
        bus.mem_ack  = 1'b0;
        bus.mem_data = '0;
        bus.ir_ready = 1'b0;

        // reset state, branch masked during reset
        #12;
        br_taken = 1'b1; br_target = 8'h55;
        #1;
        check("rst_mem_rd",   bus.mem_rd,   0);
        check("rst_inc",      Inc_PC,       0);
        check("rst_load",     Load_PC,      0);
        check("rst_pc_data",  pc_data,      0);
        check("rst_ir_valid", bus.ir_valid, 0);
        check("rst_ir_out",   bus.ir_out,   0);
        check("rst_halted",   halted,       0);
        br_taken = 1'b0;

        // basic fetch, ack on third REQ cycle
        @(negedge clk); rst = 1'b1; enable = 1'b1; #1;
        check("idle_mem_rd", bus.mem_rd, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) begin bus.mem_ack = 1'b1; bus.mem_data = 16'h1234; end
            #1;
            check("req_mem_rd",   bus.mem_rd,   1);
            check("req_addr",     bus.mem_addr, 8'h00);
            check("req_inc",      Inc_PC,       (i == 2) ? 1 : 0);
        end
        @(negedge clk); bus.mem_ack = 1'b0; #1;
        check("hold_valid",  bus.ir_valid, 1);
        check("hold_ir",     bus.ir_out,   16'h1234);
        check("hold_mem_rd", bus.mem_rd,   0);
        check("hold_count",  count,        8'h01);

        // decoder stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("stall_valid",  bus.ir_valid, 1);
            check("stall_ir",     bus.ir_out,   16'h1234);
            check("stall_mem_rd", bus.mem_rd,   0);
            check("stall_inc",    Inc_PC,       0);
        end
        @(negedge clk); bus.ir_ready = 1'b1; #1;
        check("xfer_valid", bus.ir_valid, 1);
        @(negedge clk); bus.ir_ready = 1'b0; #1;
        check("refetch_rd",    bus.mem_rd,   1);
        check("refetch_addr",  bus.mem_addr, 8'h01);
        check("refetch_valid", bus.ir_valid, 0);

        // branch coincident with mem_ack
        @(negedge clk);
        bus.mem_ack = 1'b1; bus.mem_data = 16'h5555; br_taken = 1'b1; br_target = 8'h40;
        #1;
        check("brack_load",    Load_PC, 1);
        check("brack_pc_data", pc_data, 8'h40);
        check("brack_inc",     Inc_PC,  0);
        @(negedge clk); bus.mem_ack = 1'b0; br_taken = 1'b0; #1;
        check("brack_valid", bus.ir_valid, 0);
        check("brack_rd",    bus.mem_rd,   1);
        check("brack_addr",  bus.mem_addr, 8'h40);
        check("brack_ir",    bus.ir_out,   16'h1234);
        check("brack_load0", Load_PC,      0);

        // halt opcode, then branch out of HALTED
        @(negedge clk); bus.mem_ack = 1'b1; bus.mem_data = 16'hF000; #1;
        check("halt_inc", Inc_PC, 1);
        @(negedge clk); bus.mem_ack = 1'b0; bus.ir_ready = 1'b1; #1;
        check("halt_valid", bus.ir_valid, 1);
        check("halt_ir",    bus.ir_out,   16'hF000);
        @(negedge clk); bus.ir_ready = 1'b0; #1;
        check("halted",        halted,       1);
        check("halted_rd",     bus.mem_rd,   0);
        check("halted_valid",  bus.ir_valid, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("halted_stay", halted,     1);
            check("halted_nord", bus.mem_rd, 0);
        end
        @(negedge clk); br_taken = 1'b1; br_target = 8'h10; #1;
        check("unhalt_load", Load_PC, 1);
        check("unhalt_pc",   pc_data, 8'h10);
        @(negedge clk); br_taken = 1'b0; #1;
        check("unhalt_halted", halted,       0);
        check("unhalt_rd",     bus.mem_rd,   1);
        check("unhalt_addr",   bus.mem_addr, 8'h10);

        // asynchronous reset during REQ, stale ack afterwards
        @(negedge clk); #1; rst = 1'b0; #1;
        check("arst_rd",     bus.mem_rd,   0);
        check("arst_ir",     bus.ir_out,   0);
        check("arst_valid",  bus.ir_valid, 0);
        check("arst_halted", halted,       0);
        check("arst_inc",    Inc_PC,       0);
        check("arst_load",   Load_PC,      0);
        check("arst_pc",     pc_data,      0);
        enable = 1'b0;
        @(negedge clk); rst = 1'b1; #1;
        check("post_rst_rd", bus.mem_rd, 0);
        @(negedge clk); bus.mem_ack = 1'b1; bus.mem_data = 16'hABCD; #1;
        check("stale_inc", Inc_PC,     0);
        check("stale_rd",  bus.mem_rd, 0);
        @(negedge clk); bus.mem_ack = 1'b0; #1;
        check("stale_ir",    bus.ir_out,   0);
        check("stale_valid", bus.ir_valid, 0);
        check("stale_count", count,        0);

        // PC wrap from 0xFF
        @(negedge clk); br_taken = 1'b1; br_target = 8'hFF; enable = 1'b1; #1;
        check("wrap_load", Load_PC, 1);
        @(negedge clk); br_taken = 1'b0; bus.mem_ack = 1'b1; bus.mem_data = 16'h2222; #1;
        check("wrap_addr_ff", bus.mem_addr, 8'hFF);
        check("wrap_inc",     Inc_PC,       1);
        check("wrap_rd",      bus.mem_rd,   1);
        @(negedge clk); bus.mem_ack = 1'b0; bus.ir_ready = 1'b1; #1;
        check("wrap_ir",    bus.ir_out,   16'h2222);
        check("wrap_addr0", bus.mem_addr, 8'h00);
        check("wrap_valid", bus.ir_valid, 1);
        @(negedge clk); bus.ir_ready = 1'b0; #1;
        check("wrap_next_rd",   bus.mem_rd,   1);
        check("wrap_next_addr", bus.mem_addr, 8'h00);

        // branch coincident with hand-off of a halt opcode
        @(negedge clk); bus.mem_ack = 1'b1; bus.mem_data = 16'hF123; #1;
        check("brx_inc", Inc_PC, 1);
        @(negedge clk);
        bus.mem_ack = 1'b0; bus.ir_ready = 1'b1; br_taken = 1'b1; br_target = 8'h20;
        #1;
        check("brx_valid", bus.ir_valid, 1);
        check("brx_load",  Load_PC,      1);
        check("brx_pc",    pc_data,      8'h20);
        @(negedge clk); bus.ir_ready = 1'b0; br_taken = 1'b0; #1;
        check("brx_halted", halted,       0);
        check("brx_rd",     bus.mem_rd,   1);
        check("brx_addr",   bus.mem_addr, 8'h20);
        check("brx_valid0", bus.ir_valid, 0);

        // enable drops during an outstanding read
        @(negedge clk); enable = 1'b0; #1;
        check("drop_rd", bus.mem_rd, 1);
        @(negedge clk); bus.mem_ack = 1'b1; bus.mem_data = 16'h0101; #1;
        check("drop_inc", Inc_PC, 1);
        @(negedge clk); bus.mem_ack = 1'b0; bus.ir_ready = 1'b1; #1;
        check("drop_valid", bus.ir_valid, 1);
        check("drop_ir",    bus.ir_out,   16'h0101);
        @(negedge clk); bus.ir_ready = 1'b0; #1;
        check("drop_idle_rd",    bus.mem_rd,   0);
        check("drop_idle_valid", bus.ir_valid, 0);
        check("drop_idle_halt",  halted,       0);
        @(negedge clk); #1;
        check("drop_stay_rd", bus.mem_rd, 0);

        @(negedge clk); #3;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
